// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Single-outstanding instruction fetch controller. It issues one
//               instruction-memory request per fetch, then holds the returned
//               word for decode and steers the external pc register through
//               sequential increments and branch/jump redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] PC_Dout,
    output logic [31:0] PC_Data,
    output logic        PC_LdEn,
    input  logic        Redirect,
    input  logic [31:0] RedirTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdata,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        DecodeReady
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_flush_pend;
    logic        w_flush_pend_nxt;
    logic [31:0] r_saved_target;
    logic [31:0] w_saved_target_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        w_capture;
    logic [31:0] w_pc_inc;

    // Sequential next PC; 32-bit addition wraps naturally at the top of memory.
    assign w_pc_inc = PC_Dout + PC_STEP;

    // Request and valid are pure state decodes so that an asynchronous reset
    // drops them in the same instant the state register clears.
    assign IMemReq    = (r_state == WAIT);
    assign IMemAddr   = PC_Dout;
    assign InstrValid = (r_state == HOLD);
    assign Instr      = r_instr;
    assign InstrPC    = r_instr_pc;

    // State, pending-flush flag and saved redirect target.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= IDLE;
            r_flush_pend   <= 1'b0;
            r_saved_target <= 32'd0;
        end else begin
            r_state        <= w_next_state;
            r_flush_pend   <= w_flush_pend_nxt;
            r_saved_target <= w_saved_target_nxt;
        end
    end

    // Capture the returned instruction and its address on a clean completion.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
        end else if (w_capture) begin
            r_instr    <= IMemRdata;
            r_instr_pc <= PC_Dout;
        end
    end

    // Next-state, pc-register steering and flush bookkeeping.
    always_comb begin
        w_next_state       = r_state;
        w_flush_pend_nxt   = r_flush_pend;
        w_saved_target_nxt = r_saved_target;
        w_capture          = 1'b0;
        PC_LdEn            = 1'b0;
        PC_Data            = w_pc_inc;

        case (r_state)
            IDLE: begin
                if (Redirect) begin
                    // Load the new PC first; the fetch starts one cycle later
                    // so the address it uses is already the redirect target.
                    PC_LdEn      = 1'b1;
                    PC_Data      = RedirTarget;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end

            WAIT: begin
                if (IMemAck) begin
                    if (r_flush_pend || Redirect) begin
                        // Fetched word belongs to the wrong path: drop it.
                        PC_LdEn          = 1'b1;
                        PC_Data          = Redirect ? RedirTarget : r_saved_target;
                        w_flush_pend_nxt = 1'b0;
                        w_next_state     = IDLE;
                    end else begin
                        PC_LdEn      = 1'b1;
                        PC_Data      = w_pc_inc;
                        w_capture    = 1'b1;
                        w_next_state = HOLD;
                    end
                end else if (Redirect) begin
                    // The bus transaction cannot be aborted; remember where
                    // to go once it completes. A newer redirect wins.
                    w_flush_pend_nxt   = 1'b1;
                    w_saved_target_nxt = RedirTarget;
                end
            end

            HOLD: begin
                if (Redirect) begin
                    // Squash the held instruction even if decode is ready.
                    PC_LdEn      = 1'b1;
                    PC_Data      = RedirTarget;
                    w_next_state = IDLE;
                end else if (DecodeReady) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
